// File: rtl/echo_report_tx_if.sv
// +-----------------------------------------------------------------------+
// | echo_report_tx_if : request/report and UART handshake bundle          |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

interface echo_report_tx_if #(
   parameter int DATA_W = 24
);
   logic              start;
   logic [DATA_W-1:0] value;
   logic              busy;
   logic              done;
   logic              uart_transmit;
   logic [7:0]        uart_tx_byte;
   logic              uart_is_transmitting;

   modport slave (
      input  start, value, uart_is_transmitting,
      output busy, done, uart_transmit, uart_tx_byte
   );

   modport master (
      output start, value, uart_is_transmitting,
      input  busy, done, uart_transmit, uart_tx_byte
   );
endinterface

`default_nettype wire

// File: rtl/echo_report_tx.sv
// +-----------------------------------------------------------------------+
// | echo_report_tx : sends an unsigned value as ASCII decimal + CR LF     |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module echo_report_tx #(
   parameter int DATA_W = 24,
   parameter int DIGITS = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   echo_report_tx_if.slave bus
);
   localparam int BCD_W = 4 * DIGITS;
   localparam int CNT_W = $clog2(DATA_W + 1);
   localparam int PTR_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_CONVERT = 3'd1;
   localparam logic [2:0] S_SKIP    = 3'd2;
   localparam logic [2:0] S_LOAD    = 3'd3;
   localparam logic [2:0] S_WAIT_HI = 3'd4;
   localparam logic [2:0] S_WAIT_LO = 3'd5;
   localparam logic [2:0] S_NEXT    = 3'd6;
   localparam logic [2:0] S_DONE    = 3'd7;

   localparam logic [1:0] SEL_DIG = 2'd0;
   localparam logic [1:0] SEL_CR  = 2'd1;
   localparam logic [1:0] SEL_LF  = 2'd2;

   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DATA_W);
   localparam logic [PTR_W-1:0] PTR_MSD  = PTR_W'(DIGITS - 1);

   logic [2:0]        state_q, state_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic [BCD_W-1:0]  bcd_q, bcd_d;
   logic [BCD_W-1:0]  bcd_adj;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [PTR_W-1:0]  ptr_q, ptr_d;
   logic [1:0]        sel_q, sel_d;
   logic [1:0]        wait_q, wait_d;
   logic [7:0]        byte_q, byte_d;

   function automatic logic [3:0] nib_at(input logic [BCD_W-1:0] b,
                                         input logic [PTR_W-1:0] p);
      logic [3:0] n;
      n = 4'd0;
      for (int i = 0; i < DIGITS; i++) begin
         if (p == PTR_W'(i)) n = b[4*i +: 4];
      end
      return n;
   endfunction

   function automatic logic [7:0] char_of(input logic [BCD_W-1:0] b,
                                          input logic [PTR_W-1:0] p,
                                          input logic [1:0]       s);
      logic [7:0] c;
      case (s)
         SEL_DIG: c = {4'h3, nib_at(b, p)};
         SEL_CR:  c = 8'h0D;
         default: c = 8'h0A;
      endcase
      return c;
   endfunction

   // Double-dabble correction applied to every digit before each shift
   for (genvar i = 0; i < DIGITS; i++) begin : g_dabble
      assign bcd_adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? (bcd_q[4*i +: 4] + 4'd3)
                                                           : bcd_q[4*i +: 4];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         shift_q <= '0;
         bcd_q   <= '0;
         cnt_q   <= '0;
         ptr_q   <= '0;
         sel_q   <= SEL_DIG;
         wait_q  <= '0;
         byte_q  <= 8'h00;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         bcd_q   <= bcd_d;
         cnt_q   <= cnt_d;
         ptr_q   <= ptr_d;
         sel_q   <= sel_d;
         wait_q  <= wait_d;
         byte_q  <= byte_d;
      end
   end

   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      bcd_d   = bcd_q;
      cnt_d   = cnt_q;
      ptr_d   = ptr_q;
      sel_d   = sel_q;
      wait_d  = wait_q;
      byte_d  = byte_q;
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               shift_d = bus.value;
               bcd_d   = '0;
               cnt_d   = CNT_LOAD;
               ptr_d   = PTR_MSD;
               sel_d   = SEL_DIG;
               state_d = S_CONVERT;
            end
         end
         S_CONVERT: begin
            bcd_d   = {bcd_adj[BCD_W-2:0], shift_q[DATA_W-1]};
            shift_d = shift_q << 1;
            cnt_d   = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) state_d = S_SKIP;
         end
         S_SKIP: begin
            if ((nib_at(bcd_q, ptr_q) == 4'd0) && (ptr_q != '0)) ptr_d = ptr_q - PTR_W'(1);
            else                                                 state_d = S_LOAD;
         end
         S_LOAD: begin
            if (!bus.uart_is_transmitting) begin
               wait_d  = 2'd0;
               state_d = S_WAIT_HI;
            end
         end
         S_WAIT_HI: begin
            // Four cycles without acknowledge means the request was lost; resend it
            if (bus.uart_is_transmitting) state_d = S_WAIT_LO;
            else if (wait_q == 2'd3)      state_d = S_LOAD;
            else                          wait_d  = wait_q + 2'd1;
         end
         S_WAIT_LO: begin
            if (!bus.uart_is_transmitting) state_d = S_NEXT;
         end
         S_NEXT: begin
            state_d = S_LOAD;
            case (sel_q)
               SEL_DIG: begin
                  if (ptr_q == '0) sel_d = SEL_CR;
                  else             ptr_d = ptr_q - PTR_W'(1);
               end
               SEL_CR:  sel_d   = SEL_LF;
               default: state_d = S_DONE;
            endcase
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      // Character is latched on entry so it is valid in the very cycle of the pulse
      if (state_d == S_LOAD) byte_d = char_of(bcd_d, ptr_d, sel_d);
   end

   always_comb begin
      bus.busy          = 1'b0;
      bus.done          = 1'b0;
      bus.uart_transmit = 1'b0;
      case (state_q)
         S_IDLE: ;
         S_DONE: bus.done = 1'b1;
         S_LOAD: begin
            bus.busy          = 1'b1;
            bus.uart_transmit = !bus.uart_is_transmitting;
         end
         default: bus.busy = 1'b1;
      endcase
   end

   assign bus.uart_tx_byte = byte_q;

endmodule

`default_nettype wire

// File: tb/tb_echo_report_tx.sv
// +-----------------------------------------------------------------------+
// | tb_echo_report_tx : table, random and corner-case bench               |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_echo_report_tx;
   localparam int DATA_W   = 24;
   localparam int DIGITS   = 8;
   localparam int BASE_LAT = 1 + DATA_W + 1;

   typedef struct {
      logic [DATA_W-1:0] val;
      string             txt;
      int                lat;
   } vec_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   echo_report_tx_if #(.DATA_W(DATA_W)) bus();

   echo_report_tx #(.DATA_W(DATA_W), .DIGITS(DIGITS)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // UART model: acknowledges one cycle after a request, busy for hold_cyc cycles
   int         hold_cyc  = 3;
   int         drop_req  = 0;
   int         drop_ack  = 0;
   bit         model_clr = 1'b1;
   int         tx_left   = 0;
   logic [7:0] uart_cur  = 8'h00;
   logic [7:0] uart_q[$];

   always @(posedge clk) begin
      if (model_clr) begin
         bus.uart_is_transmitting <= 1'b0;
         tx_left                  <= 0;
      end else if (tx_left != 0) begin
         if (tx_left == 1) bus.uart_is_transmitting <= 1'b0;
         tx_left <= tx_left - 1;
      end else if (bus.uart_transmit === 1'b1 && bus.uart_is_transmitting === 1'b0) begin
         if (drop_req != drop_ack) begin
            drop_ack <= drop_ack + 1;
         end else begin
            bus.uart_is_transmitting <= 1'b1;
            tx_left                  <= hold_cyc;
            uart_cur                 <= bus.uart_tx_byte;
            uart_q.push_back(bus.uart_tx_byte);
         end
      end
   end

   logic [7:0] pulse_q[$];
   int         pulse_cyc[$];
   int         done_cnt = 0;
   bit         prev_tx  = 1'b0;
   bit         chk_en   = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic string model_text(input longint unsigned v);
      string s;
      longint unsigned r;
      if (v == 0) return "0";
      s = "";
      r = v;
      while (r != 0) begin
         s = {$sformatf("%c", 8'h30 + (r % 10)), s};
         r = r / 10;
      end
      return s;
   endfunction

   task automatic issue(input logic [DATA_W-1:0] v, output int s_cyc,
                        output int p0, output int u0, output int d0);
      p0 = pulse_q.size();
      u0 = uart_q.size();
      d0 = done_cnt;
      bus.start = 1'b1;
      bus.value = v;
      s_cyc     = cyc;
      tick();
      bus.start = 1'b0;
      bus.value = DATA_W'($urandom);
      check("busy_after_start", {31'd0, bus.busy}, 32'd1);
   endtask

   task automatic wait_done(input string name, input int d0);
      int n;
      n = 0;
      while (done_cnt == d0 && n < 4000) begin
         tick();
         n++;
      end
      check({name, "_done_seen"}, (done_cnt > d0) ? 32'd1 : 32'd0, 32'd1);
      repeat (6) tick();
      check({name, "_done_count"}, done_cnt - d0, 32'd1);
      check({name, "_busy_end"}, {31'd0, bus.busy}, 32'd0);
   endtask

   task automatic wait_pulses(input string name, input int target);
      int n;
      n = 0;
      while (pulse_q.size() < target && n < 2000) begin
         tick();
         n++;
      end
      check({name, "_pulse_seen"}, (pulse_q.size() >= target) ? 32'd1 : 32'd0, 32'd1);
   endtask

   task automatic verify(input string name, input string txt, input int lat,
                         input int s_cyc, input int p0, input int u0);
      int         len;
      logic [7:0] e;
      logic [7:0] a;
      len = txt.len();
      check({name, "_nbytes"}, uart_q.size() - u0, len + 2);
      for (int i = 0; i < len + 2; i++) begin
         e = (i < len) ? txt[i] : ((i == len) ? 8'h0D : 8'h0A);
         a = (u0 + i < uart_q.size()) ? uart_q[u0 + i] : 8'hxx;
         check($sformatf("%s_byte%0d", name, i), {24'd0, a}, {24'd0, e});
      end
      if (pulse_cyc.size() > p0) check({name, "_latency"}, pulse_cyc[p0] - s_cyc, lat);
      else                       check({name, "_latency"}, 32'hffffffff, lat);
   endtask

   initial begin
      vec_t              vecs[8];
      int                s_cyc, p0, u0, d0, w, n;
      logic [DATA_W-1:0] v;
      string             txt;

      vecs[0] = '{24'd0,        "0",        33};
      vecs[1] = '{24'd1000000,  "1000000",  27};
      vecs[2] = '{24'd16777215, "16777215", 26};
      vecs[3] = '{24'd5,        "5",        33};
      vecs[4] = '{24'd10,       "10",       32};
      vecs[5] = '{24'd100,      "100",      31};
      vecs[6] = '{24'd9999999,  "9999999",  27};
      vecs[7] = '{24'd10000000, "10000000", 26};

      bus.start = 1'b0;
      bus.value = '0;

      fork
         forever begin
            @(negedge clk);
            if (bus.uart_transmit === 1'b1) begin
               n_cmp++;
               if (prev_tx || bus.uart_is_transmitting !== 1'b0) begin
                  n_bad++;
                  $display("FAIL tx_protocol: prev_transmit=%0b is_transmitting=%0b, expected 0 and 0",
                           prev_tx, bus.uart_is_transmitting);
               end
               pulse_q.push_back(bus.uart_tx_byte);
               pulse_cyc.push_back(cyc);
               chk_en = 1'b1;
            end
            prev_tx = (bus.uart_transmit === 1'b1);
            if (!rst_n) chk_en = 1'b0;
            if (chk_en && bus.uart_is_transmitting === 1'b1) begin
               n_cmp++;
               if (bus.uart_tx_byte !== uart_cur) begin
                  n_bad++;
                  $display("FAIL byte_stable: got %0h, expected %0h", bus.uart_tx_byte, uart_cur);
               end
            end
            if (bus.done === 1'b1) done_cnt++;
         end
      join_none

      repeat (3) tick();
      check("rst_busy", {31'd0, bus.busy}, 32'd0);
      check("rst_done", {31'd0, bus.done}, 32'd0);
      check("rst_transmit", {31'd0, bus.uart_transmit}, 32'd0);
      check("rst_tx_byte", {24'd0, bus.uart_tx_byte}, 32'd0);
      model_clr = 1'b0;
      rst_n     = 1'b1;
      repeat (2) tick();
      check("idle_busy", {31'd0, bus.busy}, 32'd0);

      for (int i = 0; i < 8; i++) begin
         hold_cyc = 1 + (i % 4);
         issue(vecs[i].val, s_cyc, p0, u0, d0);
         wait_done($sformatf("vec%0d", i), d0);
         verify($sformatf("vec%0d", i), vecs[i].txt, vecs[i].lat, s_cyc, p0, u0);
      end

      for (int i = 0; i < 25; i++) begin
         w        = $urandom_range(1, DATA_W);
         v        = DATA_W'($urandom) & ((DATA_W'(1) << w) - DATA_W'(1));
         hold_cyc = $urandom_range(1, 6);
         txt      = model_text(longint'(v));
         issue(v, s_cyc, p0, u0, d0);
         wait_done($sformatf("rnd%0d", i), d0);
         verify($sformatf("rnd%0d", i), txt, BASE_LAT + DIGITS - txt.len(), s_cyc, p0, u0);
      end

      // start while busy must not disturb the report in flight
      hold_cyc = 3;
      issue(24'd1234, s_cyc, p0, u0, d0);
      wait_pulses("busy_start", p0 + 2);
      bus.start = 1'b1;
      bus.value = 24'd99;
      tick();
      bus.start = 1'b0;
      wait_done("busy_start", d0);
      verify("busy_start", "1234", 30, s_cyc, p0, u0);
      repeat (60) tick();
      check("busy_start_pulses", pulse_q.size() - p0, 32'd6);
      check("busy_start_dones", done_cnt - d0, 32'd1);

      // start coinciding with the done pulse is ignored
      issue(24'd7, s_cyc, p0, u0, d0);
      n = 0;
      while (bus.done !== 1'b1 && n < 4000) begin
         tick();
         n++;
      end
      check("done_start_seen", {31'd0, bus.done}, 32'd1);
      bus.start = 1'b1;
      bus.value = 24'd55;
      tick();
      bus.start = 1'b0;
      repeat (60) tick();
      verify("done_start", "7", 33, s_cyc, p0, u0);
      check("done_start_pulses", pulse_q.size() - p0, 32'd3);
      check("done_start_busy", {31'd0, bus.busy}, 32'd0);

      // first request lost by the UART: same byte resent 5 cycles later
      drop_req = drop_req + 1;
      issue(24'd42, s_cyc, p0, u0, d0);
      wait_done("retry", d0);
      verify("retry", "42", 32, s_cyc, p0, u0);
      check("retry_pulses", pulse_q.size() - p0, 32'd5);
      if (pulse_q.size() >= p0 + 2) begin
         check("retry_byte_a", {24'd0, pulse_q[p0]}, 32'h34);
         check("retry_byte_b", {24'd0, pulse_q[p0 + 1]}, 32'h34);
         check("retry_gap", pulse_cyc[p0 + 1] - pulse_cyc[p0], 32'd5);
      end

      // reset while the second digit is on the line
      hold_cyc = 6;
      issue(24'd4321, s_cyc, p0, u0, d0);
      wait_pulses("mid_rst", p0 + 2);
      n = 0;
      while (bus.uart_is_transmitting !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      tick();
      rst_n = 1'b0;
      tick();
      check("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
      check("mid_rst_transmit", {31'd0, bus.uart_transmit}, 32'd0);
      check("mid_rst_done", {31'd0, bus.done}, 32'd0);
      check("mid_rst_tx_byte", {24'd0, bus.uart_tx_byte}, 32'd0);
      rst_n = 1'b1;
      d0    = done_cnt;
      repeat (80) tick();
      check("mid_rst_no_done", done_cnt - d0, 32'd0);
      check("mid_rst_pulses", pulse_q.size() - p0, 32'd2);
      hold_cyc = 3;
      issue(24'd805, s_cyc, p0, u0, d0);
      wait_done("after_rst", d0);
      verify("after_rst", "805", 31, s_cyc, p0, u0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/echo_report_tx.md
ECHO_REPORT_TX -- requirements
Module: echo_report_tx

Interface
REQ-001 Parameter DATA_W, default 24, width of the measured value in bits.
REQ-002 Parameter DIGITS, default 8, number of BCD digits (enough for 2^DATA_W-1).
REQ-003 clk  input  1  single system clock; all logic on its rising edge.
REQ-004 rst_n  input  1  reset; synchronous, active-low.
REQ-005 start  input  1  one-cycle request to report value; honoured only when busy=0.
REQ-006 value  input  DATA_W  unsigned cycle count; sampled in the start cycle.
REQ-007 busy  output  1  high from the cycle after an accepted start until done.
REQ-008 done  output  1  one-cycle pulse after the final LF byte has left the UART.
REQ-009 uart_transmit  output  1  one-cycle request to the downstream UART transmitter.
REQ-010 uart_tx_byte  output  8  byte to transmit; stable from uart_transmit until is_transmitting falls.
REQ-011 uart_is_transmitting  input  1  UART busy flag; high one cycle after an accepted request, low when the line is idle.

Function
REQ-012 Block SHALL emit value as unsigned ASCII decimal ("0"=0x30..0x39), followed by CR (0x0D) and LF (0x0A).
REQ-013 Leading zeros SHALL be suppressed; value 0 SHALL emit exactly one "0"; internal and trailing zeros SHALL always be emitted.
REQ-014 States: IDLE, CONVERT, SKIP, LOAD, WAIT_HI, WAIT_LO, NEXT, DONE.
REQ-015 IDLE: on start=1, latch value, clear BCD register, load shift count DATA_W, go to CONVERT; busy rises the next cycle.
REQ-016 CONVERT: sequential double-dabble, one bit per cycle (add 3 to each BCD nibble >=5, then shift left 1); exactly DATA_W cycles, then SKIP.
REQ-017 SKIP: one cycle per leading zero nibble, advancing digit pointer from most significant; stop on first nonzero nibble or at the least significant digit; then LOAD.
REQ-018 LOAD: drive uart_tx_byte with the current character and pulse uart_transmit for exactly one cycle, only if uart_is_transmitting=0; otherwise hold in LOAD.
REQ-019 WAIT_HI: wait for uart_is_transmitting=1; if not seen within 4 cycles after the pulse, re-enter LOAD and retry the same byte.
REQ-020 WAIT_LO: wait for uart_is_transmitting=0, then NEXT.
REQ-021 NEXT: advance character sequence digit(s) -> CR -> LF; after LF go to DONE, else LOAD.
REQ-022 DONE: assert done for one cycle, deassert busy, return to IDLE; start in this cycle SHALL be ignored.
REQ-023 start while busy=1 SHALL be ignored without changing the latched value or the byte sequence.
REQ-024 uart_transmit SHALL never be high on two consecutive cycles nor while uart_is_transmitting=1.
REQ-025 BCD register SHALL be 4*DIGITS bits; no nibble SHALL exceed 9 after conversion for any DATA_W-bit input.
REQ-026 Latency start -> first uart_transmit SHALL be 1 + DATA_W + (number of suppressed zeros) + 1 cycles when the UART is idle.

Reset
REQ-027 With rst_n=0 at a clock edge: state=IDLE, busy=0, done=0, uart_transmit=0, uart_tx_byte=0x00, BCD/shift registers cleared.
REQ-028 Reset mid-operation SHALL abandon the report immediately; a byte already in the UART is not recalled; no done pulse SHALL follow.
REQ-029 First start accepted SHALL be the first one seen with rst_n=1 and state IDLE.

Verification
REQ-030 value=0, start pulse, UART model idle -> bytes 0x30,0x0D,0x0A, then one done pulse.
REQ-031 value=1000000 -> "1000000\r\n" (0x31,0x30 x6,0x0D,0x0A); internal zeros preserved.
REQ-032 value=16777215 (DATA_W=24) -> "16777215\r\n"; first uart_transmit exactly 26 cycles after start.
REQ-033 value=1234, second start with value=99 during byte 2 -> only "1234\r\n" emitted, single done.
REQ-034 UART model that never raises is_transmitting on first pulse -> retry after 4 cycles, same byte, no byte skipped.
REQ-035 rst_n low during WAIT_LO of second digit -> next cycle busy=0, uart_transmit=0, no done; new start then reports correctly.
